// File: rtl/five_checker_if.sv
// Start/result handshake and board read port of the gomoku five-in-a-row checker.
// The slave side is the checker; the master side is the turn controller plus board memory.
interface five_checker_if #(
    parameter int unsigned COORD_W = 4
);
    logic               start;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [1:0]         player;
    logic               rd_en;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic [1:0]         rd_data;
    logic               busy;
    logic               done;
    logic               win;
    logic [3:0]         win_len;

    modport master (
        output start, x, y, player, rd_data,
        input  rd_en, rd_x, rd_y, busy, done, win, win_len
    );

    modport slave (
        input  start, x, y, player, rd_data,
        output rd_en, rd_x, rd_y, busy, done, win, win_len
    );
endinterface

// File: rtl/five_checker.sv
// Win detector: walks the board outward from the new stone in 8 directions, one read at a time,
// and reports the longest run on any of the 4 axes.
module five_checker #(
    parameter int unsigned BOARD_N = 15,
    parameter int unsigned COORD_W = 4
) (
    input logic           clock,
    input logic           resetn,
    five_checker_if.slave bus
);
    // One spare sign bit so targets at -1 and BOARD_N are distinguishable from legal cells.
    localparam int unsigned SW = COORD_W + 1;

    typedef enum logic [2:0] {StIdle, StIssue, StCompare, StNext, StDone} state_e;

    state_e             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [1:0]         player_q, player_d;
    logic [2:0]         dir_q, dir_d;
    logic [2:0]         k_q, k_d;
    logic [3:0]         acc_q, acc_d;
    logic [3:0]         win_len_q, win_len_d;
    logic               win_q, win_d;

    logic signed [SW-1:0] step_x, step_y;
    logic signed [SW-1:0] off, tx, ty;
    logic                 tgt_ok;
    logic                 rd_en;
    logic [3:0]           axis_len;

    always_comb begin
        step_x = '0;
        step_y = '0;
        unique case (dir_q)
            3'd0: begin step_x = SW'(1); step_y = '0;     end
            3'd1: begin step_x = '1;     step_y = '0;     end
            3'd2: begin step_x = '0;     step_y = SW'(1); end
            3'd3: begin step_x = '0;     step_y = '1;     end
            3'd4: begin step_x = SW'(1); step_y = SW'(1); end
            3'd5: begin step_x = '1;     step_y = '1;     end
            3'd6: begin step_x = SW'(1); step_y = '1;     end
            3'd7: begin step_x = '1;     step_y = SW'(1); end
            default: begin step_x = '0;  step_y = '0;     end
        endcase
    end

    always_comb begin
        off    = $signed(SW'(k_q) + SW'(1));
        tx     = $signed({1'b0, x_q}) + step_x * off;
        ty     = $signed({1'b0, y_q}) + step_y * off;
        tgt_ok = !tx[SW-1] && (32'(tx[COORD_W-1:0]) < BOARD_N) &&
                 !ty[SW-1] && (32'(ty[COORD_W-1:0]) < BOARD_N);
        rd_en  = (state_q == StIssue) && tgt_ok;
    end

    assign bus.rd_en   = rd_en;
    assign bus.rd_x    = rd_en ? tx[COORD_W-1:0] : '0;
    assign bus.rd_y    = rd_en ? ty[COORD_W-1:0] : '0;
    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = (state_q == StDone);
    assign bus.win     = win_q;
    assign bus.win_len = win_len_q;

    assign axis_len = 4'd1 + acc_q + {1'b0, k_q};

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        player_d  = player_q;
        dir_d     = dir_q;
        k_d       = k_q;
        acc_d     = acc_q;
        win_len_d = win_len_q;
        win_d     = win_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start && (bus.player == 2'b01 || bus.player == 2'b10)) begin
                    x_d       = bus.x;
                    y_d       = bus.y;
                    player_d  = bus.player;
                    dir_d     = '0;
                    k_d       = '0;
                    acc_d     = '0;
                    win_len_d = '0;
                    win_d     = 1'b0;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                state_d = tgt_ok ? StCompare : StNext;
            end
            StCompare: begin
                if (bus.rd_data == player_q) begin
                    k_d     = k_q + 3'd1;
                    state_d = (k_q < 3'd3) ? StIssue : StNext;
                end else begin
                    state_d = StNext;
                end
            end
            StNext: begin
                k_d = '0;
                // Odd directions close an axis: fold in the placed stone and the opposite side.
                if (dir_q[0]) begin
                    acc_d = '0;
                    if (axis_len > win_len_q) win_len_d = axis_len;
                end else begin
                    acc_d = acc_q + {1'b0, k_q};
                end
                if (dir_q == 3'd7) begin
                    win_d   = (win_len_d >= 4'd5);
                    state_d = StDone;
                end else begin
                    dir_d   = dir_q + 3'd1;
                    state_d = StIssue;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            x_q       <= '0;
            y_q       <= '0;
            player_q  <= '0;
            dir_q     <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            win_len_q <= '0;
            win_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            player_q  <= player_d;
            dir_q     <= dir_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            win_len_q <= win_len_d;
            win_q     <= win_d;
        end
    end
endmodule
